fas_frame_ctrl: RTL and testbench
=================================

FAS_FRAME_CTRL -- requirements
Module: fas_frame_ctrl

Interface
REQ-001 Parameter DW, 16, sample width of fir_d and frm_d, signed.
REQ-002 Parameter FRAME_LEN, 16, samples per FFT frame; the only supported value is 16.
REQ-003 Parameter CNT_W, 8, width of frame_cnt.
REQ-004 clk  input  1  single clock; all state changes on the rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 enable  input  1  high = accept FIR samples; low = ignore fir_valid.
REQ-007 fir_valid  input  1  one-cycle qualifier for fir_d.
REQ-008 fir_d  input  DW  signed FIR output sample.
REQ-009 frm_ready  input  1  FFT-side sink can take a sample this cycle.
REQ-010 ana_done  input  1  analyzer done pulse for the frame currently outstanding.
REQ-011 frm_valid  output  1  frm_d/frm_idx/frm_last are valid.
REQ-012 frm_d  output  DW  frame sample to the FFT.
REQ-013 frm_idx  output  4  index of frm_d within the frame, 0..15.
REQ-014 frm_last  output  1  high when frm_valid and frm_idx==15.
REQ-015 frame_cnt  output  CNT_W  frames completed (released by ana_done), saturating.
REQ-016 ovf  output  1  sticky flag: at least one accepted-enable sample was dropped.
REQ-017 busy  output  1  high when the read FSM is not in IDLE.

Function
REQ-018 Storage SHALL be two banks of 16 x DW registers (ping-pong), each with a full flag.
REQ-019 Write side: on clk with enable & fir_valid and the write bank not full, fir_d SHALL be stored at bank[wr_bank][wr_ptr] and wr_ptr SHALL increment.
REQ-020 On the write of wr_ptr==15, the write bank SHALL be marked full, wr_ptr SHALL wrap to 0 and wr_bank SHALL toggle in the same edge.
REQ-021 Arrival of enable & fir_valid while the write bank is full SHALL drop the sample, leave wr_ptr unchanged and set ovf; ovf clears only on rst.
REQ-022 fir_valid with enable low SHALL be ignored and SHALL NOT set ovf.
REQ-023 Read FSM states: IDLE, SEND, WAIT_ANA; reset state IDLE.
REQ-024 IDLE -> SEND when bank[rd_bank] is full; rd_ptr SHALL be set to 0.
REQ-025 SEND: frm_valid=1, frm_d=bank[rd_bank][rd_ptr] (combinational from the array), frm_idx=rd_ptr.
REQ-026 A transfer occurs on each clk with frm_valid & frm_ready; rd_ptr SHALL increment per transfer, and the transfer at rd_ptr==15 SHALL move the FSM to WAIT_ANA.
REQ-027 frm_valid low with frm_ready high is no transfer; while frm_ready is low, frm_d/frm_idx SHALL hold.
REQ-028 WAIT_ANA: frm_valid=0; on ana_done, bank[rd_bank] full SHALL clear, rd_bank SHALL toggle, frame_cnt SHALL increment (holding at 2^CNT_W-1) and the FSM SHALL return to IDLE.
REQ-029 ana_done in IDLE or SEND SHALL be ignored.
REQ-030 Latency: if the 16th sample of a frame is written at edge N and the read FSM is IDLE, frm_valid SHALL be high in the cycle after edge N+1.
REQ-031 Simultaneous release (REQ-028) and a write to that same bank in the same cycle: the release SHALL take priority and the sample SHALL be accepted without setting ovf.
REQ-032 Filling one bank and releasing the other in the same edge SHALL both take effect independently.
REQ-033 busy = (state != IDLE).

Reset
REQ-034 rst SHALL clear both full flags, wr_ptr, rd_ptr, wr_bank, rd_bank, frame_cnt and ovf, and force IDLE.
REQ-035 Output reset values: frm_valid=0, frm_last=0, frm_idx=0, frame_cnt=0, ovf=0, busy=0; frm_d is a don't-care when frm_valid=0.
REQ-036 rst mid-frame or mid-SEND SHALL discard partial and pending frames; the first post-reset sample SHALL be index 0 of bank 0.
REQ-037 Bank contents are not required to reset.

Verification
REQ-038 16 samples 0x0001..0x0010 with frm_ready=1 held -> frm_valid 2 cycles after the last write; frm_d 0x0001..0x0010 with idx 0..15; frm_last only on 0x0010; busy high.
REQ-039 Same frame with frm_ready toggled 1,0 -> 16 transfers, data/idx held during low cycles; one ana_done -> frame_cnt=1, busy=0.
REQ-040 48 continuous samples, no ana_done -> frames 1 and 2 are stored, samples 33..48 are dropped and ovf=1; then ana_done -> frame 2 is sent from bank 1 and frame_cnt=1.
REQ-041 Both banks full with ana_done and fir_valid in the same cycle -> the sample is stored at bank 0 index 0 and ovf stays 0.
REQ-042 rst asserted at SEND idx 7 -> next cycle frm_valid=0, busy=0, frame_cnt=0, ovf=0; the next 16 samples are emitted as a fresh frame at idx 0.
REQ-043 enable=0 with 20 fir_valid pulses -> no writes and ovf=0; 256 frames -> frame_cnt saturates at 255.

Source files
------------

// File: rtl/fas_frame_ctrl.sv
// Ping-pong frame buffer between a FIR sample stream and an FFT sink.
// Two 16-sample banks fill alternately; each full bank is streamed out, then held until the analyzer releases it.
module fas_frame_ctrl #(
  parameter int DW        = 16,
  parameter int FRAME_LEN = 16,
  parameter int CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 fir_valid,
  input  logic signed [DW-1:0] fir_d,
  input  logic                 frm_ready,
  input  logic                 ana_done,
  output logic                 frm_valid,
  output logic signed [DW-1:0] frm_d,
  output logic [3:0]           frm_idx,
  output logic                 frm_last,
  output logic [CNT_W-1:0]     frame_cnt,
  output logic                 ovf,
  output logic                 busy
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_SEND     = 2'd1;
  localparam logic [1:0] S_WAIT_ANA = 2'd2;

  localparam logic [3:0] LAST_IDX = 4'(FRAME_LEN - 1);

  logic [1:0]          state;
  logic [1:0]          state_nxt;
  logic signed [DW-1:0] mem [2][FRAME_LEN];
  logic [1:0]          full;
  logic [1:0]          full_nxt;
  logic [3:0]          wr_ptr;
  logic [3:0]          rd_ptr;
  logic                wr_bank;
  logic                rd_bank;

  logic rel_frame;
  logic wr_req;
  logic wr_ok;
  logic wr_wrap;
  logic xfer;

  // A bank being released this cycle counts as empty for the writer.
  assign rel_frame = (state == S_WAIT_ANA) && ana_done;
  assign wr_req    = enable && fir_valid;
  assign wr_ok     = wr_req && (!full[wr_bank] || (rel_frame && (rd_bank == wr_bank)));
  assign wr_wrap   = wr_ok && (wr_ptr == LAST_IDX);
  assign xfer      = (state == S_SEND) && frm_ready;

  // NOTE: sample storage has no reset; contents are only read after a full write pass.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_bank][wr_ptr] <= fir_d;
  end

  // NOTE: every variable gets a default at the top of always_comb so no latch is inferred.
  always_comb begin
    full_nxt  = full;
    state_nxt = state;
    if (rel_frame) full_nxt[rd_bank] = 1'b0;
    if (wr_wrap)   full_nxt[wr_bank] = 1'b1;
    case (state)
      S_IDLE:     if (full[rd_bank])             state_nxt = S_SEND;
      S_SEND:     if (xfer && rd_ptr == LAST_IDX) state_nxt = S_WAIT_ANA;
      S_WAIT_ANA: if (ana_done)                  state_nxt = S_IDLE;
      default:                                   state_nxt = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all updates see pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      full      <= 2'b00;
      wr_ptr    <= 4'd0;
      rd_ptr    <= 4'd0;
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      frame_cnt <= '0;
      ovf       <= 1'b0;
    end else begin
      state <= state_nxt;
      full  <= full_nxt;

      if (wr_ok) begin
        wr_ptr <= wr_wrap ? 4'd0 : wr_ptr + 4'd1;
        if (wr_wrap) wr_bank <= ~wr_bank;
      end else if (wr_req) begin
        ovf <= 1'b1;
      end

      if (state == S_IDLE && full[rd_bank]) rd_ptr <= 4'd0;
      else if (xfer)                        rd_ptr <= rd_ptr + 4'd1;

      if (rel_frame) begin
        rd_bank <= ~rd_bank;
        if (frame_cnt != {CNT_W{1'b1}}) frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

  assign frm_valid = (state == S_SEND);
  assign frm_d     = mem[rd_bank][rd_ptr];
  assign frm_idx   = rd_ptr;
  assign frm_last  = frm_valid && (rd_ptr == LAST_IDX);
  assign busy      = (state != S_IDLE);

endmodule

// File: tb/tb_fas_frame_ctrl.sv
// Bench for fas_frame_ctrl: expected frame samples are queued as they are written
// and checked against every FFT-side transfer; table-driven frames plus corner sequences.
module tb_fas_frame_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        fir_valid;
  logic [15:0] fir_d;
  logic        frm_ready;
  logic        ana_done;
  logic        frm_valid;
  logic [15:0] frm_d;
  logic [3:0]  frm_idx;
  logic        frm_last;
  logic [7:0]  frame_cnt;
  logic        ovf;
  logic        busy;

  fas_frame_ctrl #(.DW(16), .FRAME_LEN(16), .CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .fir_valid (fir_valid),
    .fir_d     (fir_d),
    .frm_ready (frm_ready),
    .ana_done  (ana_done),
    .frm_valid (frm_valid),
    .frm_d     (frm_d),
    .frm_idx   (frm_idx),
    .frm_last  (frm_last),
    .frame_cnt (frame_cnt),
    .ovf       (ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] d;
    logic [3:0]  idx;
  } exp_t;

  typedef struct {
    logic [15:0] base;
    bit          toggle;
    logic [7:0]  exp_cnt;
  } vec_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   xfers = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Scoreboard: every transfer must match the oldest queued sample; stalled output must show it too.
  always @(negedge clk) begin
    if (!rst && frm_valid) begin
      check("q_nonempty", 32'(q.size() != 0), 32'd1);
      if (q.size() != 0) begin
        check("frm_d", 32'(frm_d), 32'(q[0].d));
        check("frm_idx", 32'(frm_idx), 32'(q[0].idx));
        check("frm_last", 32'(frm_last), 32'(q[0].idx == 4'd15));
        if (frm_ready) begin
          void'(q.pop_front());
          xfers++;
        end
      end
    end
  end

  task automatic write_frame(input logic [15:0] base, input int first_idx, input int n, input bit push);
    for (int i = 0; i < n; i++) begin
      enable    = 1'b1;
      fir_valid = 1'b1;
      fir_d     = 16'(base + 16'(i));
      if (push) q.push_back('{d: fir_d, idx: 4'(first_idx + i)});
      tick();
    end
    fir_valid = 1'b0;
  endtask

  task automatic wait_ana(input string name);
    int c;
    c = 0;
    while (!(busy && !frm_valid) && c < 300) begin
      tick();
      c++;
    end
    check(name, 32'(busy && !frm_valid), 32'd1);
  endtask

  task automatic pulse_ana();
    ana_done = 1'b1;
    tick();
    ana_done = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    q.delete();
  endtask

  vec_t vecs[3];

  initial begin
    int x0;
    int c;

    vecs[0] = '{base: 16'h0001, toggle: 1'b0, exp_cnt: 8'd1};
    vecs[1] = '{base: 16'h7FF8, toggle: 1'b1, exp_cnt: 8'd2};
    vecs[2] = '{base: 16'hFFF0, toggle: 1'b1, exp_cnt: 8'd3};

    rst = 1'b1; enable = 1'b0; fir_valid = 1'b0; fir_d = '0;
    frm_ready = 1'b0; ana_done = 1'b0;
    tick(); tick(); tick();
    check("rst_frm_valid", 32'(frm_valid), 32'd0);
    check("rst_frm_last", 32'(frm_last), 32'd0);
    check("rst_frm_idx", 32'(frm_idx), 32'd0);
    check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;

    // Table-driven frames: latency, stream order, stalls, release count.
    for (int v = 0; v < 3; v++) begin
      frm_ready = 1'b1;
      x0 = xfers;
      write_frame(vecs[v].base, 0, 16, 1'b1);
      check("lat_not_yet", 32'(frm_valid), 32'd0);
      tick();
      check("lat_valid", 32'(frm_valid), 32'd1);
      check("lat_busy", 32'(busy), 32'd1);
      c = 0;
      while (!(busy && !frm_valid) && c < 100) begin
        if (vecs[v].toggle) frm_ready = ~frm_ready;
        tick();
        c++;
      end
      check("frame_done", 32'(busy && !frm_valid), 32'd1);
      check("xfer_count", 32'(xfers - x0), 32'd16);
      check("q_drained", 32'(q.size()), 32'd0);
      frm_ready = 1'b1;
      pulse_ana();
      check("tbl_frame_cnt", 32'(frame_cnt), 32'(vecs[v].exp_cnt));
      check("tbl_busy", 32'(busy), 32'd0);
    end

    // Release and write to the same bank in one cycle; then fill one bank while releasing the other.
    do_reset();
    frm_ready = 1'b1;
    write_frame(16'h1000, 0, 16, 1'b1);
    write_frame(16'h2000, 0, 16, 1'b1);
    wait_ana("sim_wait_a");
    check("sim_q_b", 32'(q.size()), 32'd16);
    enable = 1'b1; fir_valid = 1'b1; fir_d = 16'h3000; ana_done = 1'b1;
    q.push_back('{d: 16'h3000, idx: 4'd0});
    tick();
    fir_valid = 1'b0; ana_done = 1'b0;
    check("sim_ovf", 32'(ovf), 32'd0);
    check("sim_cnt1", 32'(frame_cnt), 32'd1);
    write_frame(16'h3001, 1, 14, 1'b1);
    wait_ana("sim_wait_b");
    enable = 1'b1; fir_valid = 1'b1; fir_d = 16'h300F; ana_done = 1'b1;
    q.push_back('{d: 16'h300F, idx: 4'd15});
    tick();
    fir_valid = 1'b0; ana_done = 1'b0;
    check("fill_rel_cnt", 32'(frame_cnt), 32'd2);
    wait_ana("sim_wait_c");
    check("sim_q_c", 32'(q.size()), 32'd0);
    check("sim_ovf_end", 32'(ovf), 32'd0);

    // 48 samples with no release: third frame is dropped and ovf sticks.
    do_reset();
    frm_ready = 1'b1;
    write_frame(16'd1, 0, 16, 1'b1);
    write_frame(16'd17, 0, 16, 1'b1);
    check("ovf_before_drop", 32'(ovf), 32'd0);
    write_frame(16'd33, 0, 16, 1'b0);
    wait_ana("ovf_wait1");
    check("ovf_set", 32'(ovf), 32'd1);
    check("ovf_q", 32'(q.size()), 32'd16);
    pulse_ana();
    check("ovf_cnt1", 32'(frame_cnt), 32'd1);
    tick();
    wait_ana("ovf_wait2");
    check("ovf_q2", 32'(q.size()), 32'd0);
    check("ovf_sticky", 32'(ovf), 32'd1);
    pulse_ana();
    check("ovf_cnt2", 32'(frame_cnt), 32'd2);

    // Reset in the middle of SEND; ana_done outside WAIT_ANA is ignored.
    frm_ready = 1'b0;
    write_frame(16'h0100, 0, 16, 1'b1);
    c = 0;
    while (!frm_valid && c < 20) begin tick(); c++; end
    check("mid_valid", 32'(frm_valid), 32'd1);
    pulse_ana();
    check("ana_in_send_cnt", 32'(frame_cnt), 32'd2);
    check("ana_in_send_busy", 32'(busy && frm_valid), 32'd1);
    frm_ready = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    frm_ready = 1'b0;
    check("mid_idx7", 32'(frm_idx), 32'd7);
    rst = 1'b1;
    tick();
    check("mrst_valid", 32'(frm_valid), 32'd0);
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_cnt", 32'(frame_cnt), 32'd0);
    check("mrst_ovf", 32'(ovf), 32'd0);
    rst = 1'b0;
    q.delete();
    pulse_ana();
    check("ana_in_idle_cnt", 32'(frame_cnt), 32'd0);
    frm_ready = 1'b1;
    write_frame(16'h0200, 0, 16, 1'b1);
    wait_ana("fresh_wait");
    check("fresh_q", 32'(q.size()), 32'd0);
    pulse_ana();
    check("fresh_cnt", 32'(frame_cnt), 32'd1);

    // enable low ignores fir_valid; then frame counter saturation.
    do_reset();
    enable = 1'b0;
    for (int i = 0; i < 20; i++) begin
      fir_valid = 1'b1;
      fir_d = 16'($urandom);
      tick();
    end
    fir_valid = 1'b0;
    tick(); tick(); tick();
    check("dis_ovf", 32'(ovf), 32'd0);
    check("dis_busy", 32'(busy), 32'd0);
    for (int f = 0; f < 256; f++) begin
      write_frame(16'(f * 16), 0, 16, 1'b1);
      wait_ana("sat_wait");
      pulse_ana();
      if (f == 254) check("sat_cnt255", 32'(frame_cnt), 32'd255);
    end
    check("sat_hold", 32'(frame_cnt), 32'd255);
    check("sat_q", 32'(q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
